// File: rtl/wt_sched_pkg.sv
// wt_sched_pkg: shared constants and types for the Winograd weight-transform
// job controller.
//   WT_DATA_W          default element width
//   PH_*               phase numbers of the datapath's fixed 6-cycle frame
//   sched_st_e         controller FSM states
package wt_sched_pkg;

    localparam int WT_DATA_W = 32;

    // Frame phases: columns enter at 0..PH_IN_LAST, tile columns leave at
    // PH_OUT_FIRST..PH_LAST.
    localparam logic [2:0] PH_LAUNCH    = 3'd0;
    localparam logic [2:0] PH_IN_LAST   = 3'd2;
    localparam logic [2:0] PH_OUT_FIRST = 3'd2;
    localparam logic [2:0] PH_LAST      = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } sched_st_e;

endpackage

// File: rtl/wt_col_buf.sv
// wt_col_buf: 3-entry kernel column buffer.
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_load, i_col  append one column (ignored when full)
//   i_clr          empty the buffer (end of the draining cycles)
//   i_rd_ph        frame phase; selects column 0..2, anything else reads 0
//   o_full         all three columns present
//   o_rd_col       column selected by i_rd_ph
module wt_col_buf
    import wt_sched_pkg::*;
#(
    parameter int DATA_W = WT_DATA_W
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic [3*DATA_W-1:0]   i_col,
    input  logic                  i_clr,
    input  logic [2:0]            i_rd_ph,
    output logic                  o_full,
    output logic [3*DATA_W-1:0]   o_rd_col
);

    logic [1:0]              r_cnt;
    logic [2:0][3*DATA_W-1:0] r_col;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= 2'd0;
            r_col <= '0;
        end else if (i_clr) begin
            r_cnt <= 2'd0;
        end else if (i_load && r_cnt != 2'd3) begin
            r_col[r_cnt] <= i_col;
            r_cnt        <= r_cnt + 2'd1;
        end
    end

    assign o_full = (r_cnt == 2'd3);

    always_comb begin
        o_rd_col = '0;
        case (i_rd_ph)
            3'd0:    o_rd_col = r_col[0];
            3'd1:    o_rd_col = r_col[1];
            3'd2:    o_rd_col = r_col[2];
            default: o_rd_col = '0;
        endcase
    end

endmodule

// File: rtl/wt_xform_sched.sv
// wt_xform_sched: job controller for the Winograd F(2,3) weight transform.
// Buffers 3x3 kernels arriving as 3 column beats, presents each kernel to the
// datapath in its fixed 6-phase frame and writes the 4 resulting tile columns
// to the transformed-weight buffer.
//   i_clk, i_rst                    clock, synchronous active-high reset
//   i_start, i_num_kernels,
//   i_base_addr                     job start (ignored while busy)
//   o_busy, o_done                  job in progress, 1-cycle completion pulse
//   i_k_valid, o_k_ready, i_k_col   kernel column stream {w3,w2,w1}
//   o_xf_rst_n, o_xf_col, i_xf_r    datapath reset, inputs, outputs
//   o_wr_en, o_wr_addr, o_wr_data   registered buffer write port
// Optional: WT_SCHED_PERF_EN adds o_perf_stall, a saturating count of launch
// slots lost to an incomplete buffer.
module wt_xform_sched
    import wt_sched_pkg::*;
#(
    parameter int DATA_W = WT_DATA_W,
    parameter int ADDR_W = 10,
    parameter int KCNT_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [KCNT_W-1:0]     i_num_kernels,
    input  logic [ADDR_W-1:0]     i_base_addr,
    output logic                  o_busy,
    output logic                  o_done,
    input  logic                  i_k_valid,
    output logic                  o_k_ready,
    input  logic [3*DATA_W-1:0]   i_k_col,
    output logic                  o_xf_rst_n,
    output logic [3*DATA_W-1:0]   o_xf_col,
    input  logic [4*DATA_W-1:0]   i_xf_r,
`ifdef WT_SCHED_PERF_EN
    output logic [15:0]           o_perf_stall,
`endif
    output logic                  o_wr_en,
    output logic [ADDR_W-1:0]     o_wr_addr,
    output logic [4*DATA_W-1:0]   o_wr_data
);

    sched_st_e            r_st, w_st_nxt;
    logic [2:0]           r_ph;
    logic [KCNT_W-1:0]    r_num, r_kln;
    logic [ADDR_W-1:0]    r_wptr, r_wr_addr;
    logic [4*DATA_W-1:0]  r_wr_data;
    logic                 r_fr, r_done, r_wr_en;
    logic                 w_full, w_launch, w_drain, w_cap, w_acc;
    logic                 w_start, w_last_wr;
    logic [3*DATA_W-1:0]  w_buf_rd;

    // Free-running phase mirrors the datapath's own frame counter; both are
    // released from reset on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_rst || r_ph == PH_LAST) r_ph <= PH_LAUNCH;
        else                          r_ph <= r_ph + 3'd1;
    end

    assign w_start   = (r_st == IDLE) && i_start;
    assign w_launch  = (r_st == RUN) && (r_ph == PH_LAUNCH) && w_full;
    // r_fr marks a launched frame from phase 1 through PH_LAST.
    assign w_drain   = r_fr && (r_ph != PH_LAUNCH) && (r_ph <= PH_IN_LAST);
    assign w_cap     = r_fr && (r_ph >= PH_OUT_FIRST);
    assign w_acc     = i_k_valid && o_k_ready;
    // The final tile column is written in the ph=0 cycle after the last frame.
    assign w_last_wr = (r_st == FLUSH) && (r_ph == PH_LAUNCH) && r_wr_en;

    wt_col_buf #(.DATA_W(DATA_W)) u_buf (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_acc),
        .i_col    (i_k_col),
        .i_clr    (r_fr && (r_ph == PH_IN_LAST)),
        .i_rd_ph  (r_ph),
        .o_full   (w_full),
        .o_rd_col (w_buf_rd)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_st <= IDLE;
        else       r_st <= w_st_nxt;
    end

    always_comb begin
        w_st_nxt  = r_st;
        o_busy    = (r_st != IDLE);
        o_k_ready = (r_st == RUN) && !w_full && !w_drain && (r_kln < r_num);
        o_xf_col  = (w_launch || w_drain) ? w_buf_rd : '0;
        case (r_st)
            IDLE:    if (i_start && i_num_kernels != '0) w_st_nxt = RUN;
            RUN:     if (w_launch && r_kln == r_num - KCNT_W'(1)) w_st_nxt = FLUSH;
            FLUSH:   if (w_last_wr) w_st_nxt = IDLE;
            default: w_st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_num     <= '0;
            r_kln     <= '0;
            r_wptr    <= '0;
            r_fr      <= 1'b0;
            r_done    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_done  <= (w_start && i_num_kernels == '0) || w_last_wr;
            r_wr_en <= w_cap;
            if (w_start) begin
                r_num <= i_num_kernels;
                r_kln <= '0;
            end else if (w_launch) begin
                r_kln <= r_kln + KCNT_W'(1);
            end
            if (w_launch)             r_fr <= 1'b1;
            else if (r_ph == PH_LAST) r_fr <= 1'b0;
            // Writes are strictly sequential, so a running pointer yields
            // base + 4*k + j with natural wrap.
            if (w_start) begin
                r_wptr <= i_base_addr;
            end else if (w_cap) begin
                r_wptr    <= r_wptr + ADDR_W'(1);
                r_wr_addr <= r_wptr;
                r_wr_data <= i_xf_r;
            end
        end
    end

`ifdef WT_SCHED_PERF_EN
    logic [15:0] r_perf;
    always_ff @(posedge i_clk) begin
        if (i_rst || w_start)
            r_perf <= '0;
        else if (r_st == RUN && r_ph == PH_LAUNCH && !w_full && r_kln < r_num
                 && r_perf != 16'hFFFF)
            r_perf <= r_perf + 16'd1;
    end
    assign o_perf_stall = r_perf;
`endif

    assign o_xf_rst_n = ~i_rst;
    assign o_done     = r_done;
    assign o_wr_en    = r_wr_en;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;

endmodule

// File: tb/tb_wt_xform_sched.sv
// Bench for wt_xform_sched. Contains a behavioural stand-in for the
// G*w*G^T datapath (same 6-phase frame, arithmetic-shift halving) so that
// hand-computed tiles can be checked at the buffer write port.
module tb_wt_xform_sched;

    logic          clk = 1'b0;
    logic          rst, start, kv, kr, xrn, busy, done, wen;
    logic [7:0]    nk;
    logic [9:0]    base, waddr;
    logic [95:0]   kcol, xcol;
    logic [127:0]  xr, wdata;
`ifdef WT_SCHED_PERF_EN
    logic [15:0]   perf;
`endif

    wt_xform_sched dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_kernels(nk),
        .i_base_addr(base), .o_busy(busy), .o_done(done),
        .i_k_valid(kv), .o_k_ready(kr), .i_k_col(kcol),
        .o_xf_rst_n(xrn), .o_xf_col(xcol), .i_xf_r(xr),
`ifdef WT_SCHED_PERF_EN
        .o_perf_stall(perf),
`endif
        .o_wr_en(wen), .o_wr_addr(waddr), .o_wr_data(wdata)
    );

    always #5 clk = ~clk;

    // ---------------- datapath stand-in ----------------
    logic [2:0]        dph;
    logic [2:0][95:0]  m;
    logic [127:0]      g0, g1, g2;

    function automatic logic [127:0] gcol(input logic [95:0] c);
        int w1, w2, w3;
        w1 = $signed(c[31:0]); w2 = $signed(c[63:32]); w3 = $signed(c[95:64]);
        return {32'(w3), 32'((w1 - w2 + w3) >>> 1), 32'((w1 + w2 + w3) >>> 1), 32'(w1)};
    endfunction

    function automatic logic [127:0] hs(input logic [127:0] a, input logic [127:0] b,
                                        input logic [127:0] c, input bit neg);
        logic [127:0] r;
        int x;
        for (int e = 0; e < 4; e++) begin
            x = $signed(a[e*32 +: 32]) + $signed(c[e*32 +: 32]);
            x = neg ? x - $signed(b[e*32 +: 32]) : x + $signed(b[e*32 +: 32]);
            r[e*32 +: 32] = 32'(x >>> 1);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (!xrn) begin
            dph <= 3'd0;
            m   <= '0;
        end else begin
            dph <= (dph == 3'd5) ? 3'd0 : dph + 3'd1;
            if (dph <= 3'd2) m[dph] <= xcol;
        end
    end

    always_comb begin
        g0 = gcol(m[0]);
        g1 = gcol(m[1]);
        g2 = gcol(m[2]);
        xr = '0;
        case (dph)
            3'd2:    xr = g0;
            3'd3:    xr = hs(g0, g1, g2, 1'b0);
            3'd4:    xr = hs(g0, g1, g2, 1'b1);
            3'd5:    xr = g2;
            default: xr = '0;
        endcase
    end

    // ---------------- monitors ----------------
    typedef struct { logic [9:0] a; logic [127:0] d; int c; } wr_t;
    wr_t wq[$];
    int  cyc = 0, ndone = 0, done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (wen) wq.push_back('{waddr, wdata, cyc});
        if (done) begin ndone <= ndone + 1; done_cyc <= cyc; end
    end

    // ---------------- checking helpers ----------------
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    function automatic logic [95:0] pk3(input int w1, input int w2, input int w3);
        return {32'(w3), 32'(w2), 32'(w1)};
    endfunction

    function automatic logic [127:0] pk4(input int r1, input int r2, input int r3, input int r4);
        return {32'(r4), 32'(r3), 32'(r2), 32'(r1)};
    endfunction

    typedef struct {
        logic [9:0]        base;
        logic [2:0][95:0]  col;
        logic [3:0][127:0] exp;
    } vec_t;
    vec_t tbl[4];
    logic [95:0] bq[$];

    task automatic start_job(input int n, input logic [9:0] b, output int sc);
        start = 1'b1; nk = 8'(n); base = b; sc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic feed();
        int i = 0, g = 0;
        while (i < bq.size() && g < 500) begin
            kv = 1'b1; kcol = bq[i];
            if (kr) i++;
            tick(); g++;
        end
        kv = 1'b0; kcol = '0;
        chk("feed beats accepted", 128'(i), 128'(bq.size()));
    endtask

    task automatic wait_done(input int snap);
        int g = 0;
        while (ndone == snap && g < 200) begin tick(); g++; end
        chk("done within bound", 128'(ndone > snap), 128'(1));
        repeat (3) tick();
    endtask

    // Compares nk*4 writes starting at queue index w0 against kernels ks.
    task automatic chk_writes(input string nm, input int w0, input logic [9:0] b,
                              input int ks[$]);
        logic [9:0] ea;
        chk({nm, " write count"}, 128'(wq.size() - w0), 128'(4 * ks.size()));
        if (wq.size() >= w0 + 4 * ks.size()) begin
            for (int i = 0; i < 4 * ks.size(); i++) begin
                ea = b + 10'(i);
                chk({nm, " addr"}, 128'(wq[w0+i].a), 128'(ea));
                chk({nm, " data"}, wq[w0+i].d, tbl[ks[i/4]].exp[i%4]);
                chk({nm, " write cycle"}, 128'(wq[w0+i].c),
                    128'(wq[w0].c + (i / 4) * 6 + i % 4));
            end
            chk({nm, " done cycle"}, 128'(done_cyc), 128'(wq[w0+4*ks.size()-1].c + 1));
        end
    endtask

    initial begin
        int sc, w0, d0, g;
        int ks[$];

        tbl[0].base = 10'd0;
        tbl[0].col  = {pk3(0,0,0), pk3(0,0,0), pk3(4,0,0)};
        tbl[0].exp  = {pk4(0,0,0,0), pk4(2,1,1,0), pk4(2,1,1,0), pk4(4,2,2,0)};
        tbl[1].base = 10'd16;
        tbl[1].col  = {pk3(0,0,0), pk3(0,0,0), pk3(-3,0,0)};
        tbl[1].exp  = {pk4(0,0,0,0), pk4(-2,-1,-1,0), pk4(-2,-1,-1,0), pk4(-3,-2,-2,0)};
        tbl[2].base = 10'd1022;
        tbl[2].col  = {pk3(7,8,9), pk3(4,5,6), pk3(1,2,3)};
        tbl[2].exp  = {pk4(7,12,4,9), pk4(2,4,1,3), pk4(6,11,3,9), pk4(1,3,1,3)};
        tbl[3].base = 10'd100;
        tbl[3].col  = {pk3(2,-1,3), pk3(0,0,0), pk3(-5,1,0)};
        tbl[3].exp  = {pk4(2,2,3,3), pk4(-2,0,0,1), pk4(-2,0,0,1), pk4(-5,-2,-3,0)};

        rst = 1'b1; start = 1'b0; nk = '0; base = '0; kv = 1'b0; kcol = '0;
        repeat (2) tick();
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset done", 128'(done), 128'(0));
        chk("reset k_ready", 128'(kr), 128'(0));
        chk("reset xf_col", 128'(xcol), 128'(0));
        chk("reset xf_rst_n", 128'(xrn), 128'(0));
        chk("reset wr_en", 128'(wen), 128'(0));
        chk("reset wr_addr", 128'(waddr), 128'(0));
        chk("reset wr_data", wdata, 128'(0));
`ifdef WT_SCHED_PERF_EN
        chk("reset perf_stall", 128'(perf), 128'(0));
`endif
        rst = 1'b0;
        repeat (2) tick();

        // Single-kernel table: impulse, negative rounding, wrap, mixed signs.
        for (int v = 0; v < 4; v++) begin
            w0 = wq.size(); d0 = ndone;
            bq.delete();
            for (int c = 0; c < 3; c++) bq.push_back(tbl[v].col[c]);
            start_job(1, tbl[v].base, sc);
            feed();
            wait_done(d0);
            ks = '{v};
            chk_writes($sformatf("vec%0d", v), w0, tbl[v].base, ks);
            chk("single done pulse", 128'(ndone - d0), 128'(1));
            chk("idle after job", 128'(busy), 128'(0));
        end

        // Zero-kernel job.
        w0 = wq.size(); d0 = ndone;
        start_job(0, 10'd7, sc);
        chk("zero job done next cycle", 128'(done), 128'(1));
        chk("zero job busy", 128'(busy), 128'(0));
        chk("zero job k_ready", 128'(kr), 128'(0));
        tick();
        chk("zero job done one cycle", 128'(done), 128'(0));
        repeat (4) tick();
        chk("zero job no writes", 128'(wq.size() - w0), 128'(0));

        // Streaming: three kernels back to back, k_valid held high.
        w0 = wq.size(); d0 = ndone;
        bq.delete();
        ks = '{0, 2, 3};
        foreach (ks[i]) for (int c = 0; c < 3; c++) bq.push_back(tbl[ks[i]].col[c]);
        start_job(3, 10'd200, sc);
        feed();
        wait_done(d0);
        chk_writes("stream", w0, 10'd200, ks);
        chk("stream single done", 128'(ndone - d0), 128'(1));

        // Supplier bubble: start so RUN begins at ph3, stall 4 cycles after beat 1.
        g = 0;
        while (dph != 3'd2 && g < 20) begin tick(); g++; end
        w0 = wq.size(); d0 = ndone;
        start_job(1, 10'd300, sc);
        kv = 1'b1; kcol = tbl[3].col[0];
        chk("bubble beat0 ready", 128'(kr), 128'(1));
        tick();
        kcol = tbl[3].col[1];
        tick();
        kv = 1'b0; kcol = '0;
        repeat (4) tick();
        kv = 1'b1; kcol = tbl[3].col[2];
        chk("bubble beat2 ready", 128'(kr), 128'(1));
        tick();
        kv = 1'b0; kcol = '0;
        wait_done(d0);
        ks = '{3};
        chk_writes("bubble", w0, 10'd300, ks);
        if (wq.size() > w0) chk("bubble launch slip", 128'(wq[w0].c), 128'(sc + 13));
        chk("bubble done time", 128'(done_cyc), 128'(sc + 17));
`ifdef WT_SCHED_PERF_EN
        chk("bubble perf_stall", 128'(perf), 128'(1));
`endif

        // Reset mid-job after the second write of kernel 0.
        w0 = wq.size(); d0 = ndone;
        bq.delete();
        for (int c = 0; c < 3; c++) bq.push_back(tbl[2].col[c]);
        start_job(1, 10'd500, sc);
        feed();
        g = 0;
        while (wq.size() < w0 + 2 && g < 100) begin tick(); g++; end
        chk("two writes before reset", 128'(wq.size() - w0), 128'(2));
        rst = 1'b1;
        #1;
        chk("mid rst xf_rst_n", 128'(xrn), 128'(0));
        tick();
        chk("mid rst busy", 128'(busy), 128'(0));
        chk("mid rst done", 128'(done), 128'(0));
        chk("mid rst k_ready", 128'(kr), 128'(0));
        chk("mid rst xf_col", 128'(xcol), 128'(0));
        chk("mid rst wr_en", 128'(wen), 128'(0));
        chk("mid rst wr_addr", 128'(waddr), 128'(0));
        chk("mid rst wr_data", wdata, 128'(0));
        rst = 1'b0;
        repeat (12) tick();
        chk("no writes after reset", 128'(wq.size() - w0), 128'(2));
        chk("no done after reset", 128'(ndone - d0), 128'(0));

        // Fresh job after the abort.
        w0 = wq.size(); d0 = ndone;
        bq.delete();
        for (int c = 0; c < 3; c++) bq.push_back(tbl[0].col[c]);
        start_job(1, 10'd40, sc);
        feed();
        wait_done(d0);
        ks = '{0};
        chk_writes("post reset", w0, 10'd40, ks);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
